// File: rtl/psg_wt_fetch_sched_if.sv
// Bus/request bundle between the PSG wave-table channels, the fetch scheduler
// and the upstream system-bus read port.
interface psg_wt_fetch_sched_if #(
    parameter int unsigned NCH = 8,
    parameter int unsigned AW  = 24,
    parameter int unsigned DW  = 16
);
    logic [NCH-1:0]    req;
    logic [NCH*AW-1:0] adr_i;
    logic              cyc_o;
    logic              stb_o;
    logic [AW-1:0]     adr_o;
    logic              ack_i;
    logic [DW-1:0]     dat_i;
    logic [NCH-1:0]    gnt;
    logic [2:0]        gntn;
    logic [DW-1:0]     dat_o;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    err;

    // Scheduler side: drives the bus cycle and the per-channel results.
    modport master (
        input  req, adr_i, ack_i, dat_i,
        output cyc_o, stb_o, adr_o, gnt, gntn, dat_o, done, err
    );

    // Channel/bus side: posts requests and answers the read.
    modport slave (
        output req, adr_i, ack_i, dat_i,
        input  cyc_o, stb_o, adr_o, gnt, gntn, dat_o, done, err
    );
endinterface

// File: rtl/psg_wt_fetch_sched.sv
// Round-robin wave-table fetch scheduler: grants one channel at a time a single
// bus read, returns data with a done pulse, aborts stalled reads with err.
module psg_wt_fetch_sched #(
    parameter int unsigned NCH = 8,
    parameter int unsigned AW  = 24,
    parameter int unsigned DW  = 16,
    parameter int unsigned TMO = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    psg_wt_fetch_sched_if.master  bus
);
    localparam int unsigned IW = $clog2(NCH);

    typedef enum logic {IDLE, BUS} state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [2:0]     gntn_q, gntn_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic [7:0]     tmr_q, tmr_d;
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] err_q, err_d;

    logic [NCH-1:0] rot;
    logic           found;
    logic [2:0]     pick;
    logic [2:0]     ptr_next;

    // Requests rotated so bit 0 is the channel at ptr; first set bit wins.
    always_comb begin
        rot   = (bus.req >> ptr_q) | (bus.req << (32'(NCH) - 32'(ptr_q)));
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && rot[i[IW-1:0]]) begin
                found = 1'b1;
                pick  = 3'((32'(ptr_q) + i) % NCH);
            end
        end
    end

    assign ptr_next = (gntn_q == 3'(NCH - 1)) ? 3'd0 : gntn_q + 3'd1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gntn_d  = gntn_q;
        ptr_d   = ptr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        tmr_d   = tmr_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUS;
                    gnt_d   = NCH'(1) << pick;
                    gntn_d  = pick;
                    adr_d   = bus.adr_i[32'(pick)*AW +: AW];
                    tmr_d   = '0;
                end
            end
            BUS: begin
                // ack is checked first so a coincident timeout still completes.
                if (bus.ack_i) begin
                    dat_d   = bus.dat_i;
                    done_d  = gnt_q;
                    ptr_d   = ptr_next;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (tmr_q == 8'(TMO - 1)) begin
                    err_d   = gnt_q;
                    ptr_d   = ptr_next;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done/err are registered, so with ce low a pulse holds until the next ce edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gntn_q  <= '0;
            ptr_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            tmr_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gntn_q  <= gntn_d;
            ptr_q   <= ptr_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.cyc_o = (state_q == BUS);
    assign bus.stb_o = (state_q == BUS);
    assign bus.adr_o = adr_q;
    assign bus.gnt   = gnt_q;
    assign bus.gntn  = gntn_q;
    assign bus.dat_o = dat_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule
